// File: rtl/cnn_run_checker_if.sv
// Start handshake and SRAM read-port bundle between the run checker
// and the accelerator/SRAMs. master = checker side, slave = DUT/SRAM side.
interface cnn_run_checker_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  dut_run;
    logic                  dut_busy;
    logic [ADDR_WIDTH-1:0] res_sram_read_address;
    logic [DATA_WIDTH-1:0] res_sram_read_data;
    logic [ADDR_WIDTH-1:0] gold_sram_read_address;
    logic [DATA_WIDTH-1:0] gold_sram_read_data;

    modport master (
        output dut_run,
        output res_sram_read_address,
        output gold_sram_read_address,
        input  dut_busy,
        input  res_sram_read_data,
        input  gold_sram_read_data
    );

    modport slave (
        input  dut_run,
        input  res_sram_read_address,
        input  gold_sram_read_address,
        output dut_busy,
        output res_sram_read_data,
        output gold_sram_read_data
    );
endinterface

// File: rtl/cnn_run_checker.sv
// Host-side run sequencer/result checker: starts the accelerator, measures
// compute latency, then compares result vs golden SRAM words.
// Ports: clk, reset_b, start/result_base/num_results (request),
// seq_busy/done/pass/timeout/correct_count/cycle_count (status), bus (master).
module cnn_run_checker #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 16,
    parameter int CNT_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 10,
    parameter int BUSY_TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] result_base,
    input  logic [ADDR_WIDTH:0]   num_results,
    output logic                  seq_busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ADDR_WIDTH:0]   correct_count,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    cnn_run_checker_if.master     bus
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 2);
    localparam int SW = $clog2(SETTLE_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IDLE, S_RUN, S_WAIT_DONE,
        S_SETTLE, S_READ, S_FINISH
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   num_q;
    logic [ADDR_WIDTH:0]   idx_q;
    logic [ADDR_WIDTH:0]   correct_q;
    logic [CNT_WIDTH-1:0]  cyc_q;
    logic [TW-1:0]         tmo_q;
    logic [SW-1:0]         settle_q;
    logic                  run_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic                  timeout_q;

    logic [CNT_WIDTH-1:0]  cyc_d;
    logic [ADDR_WIDTH:0]   correct_d;
    logic                  hit_d;

    always_comb begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
        // idx 0 is the first address cycle: no read data is back yet.
        hit_d = (idx_q != '0) &&
                (bus.res_sram_read_data == bus.gold_sram_read_data);
        correct_d = hit_d ? correct_q + 1'b1 : correct_q;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            correct_q <= '0;
            cyc_q     <= '0;
            tmo_q     <= '0;
            settle_q  <= '0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q    <= result_base;
                        num_q     <= num_results;
                        cyc_q     <= '0;
                        correct_q <= '0;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!bus.dut_busy) begin
                        run_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    cyc_q <= cyc_d;
                    tmo_q <= tmo_q + 1'b1;
                    if (bus.dut_busy) begin
                        run_q   <= 1'b0;
                        state_q <= S_WAIT_DONE;
                    end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
                        run_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_FINISH;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.dut_busy) begin
                        cyc_q <= cyc_d;
                    end else begin
                        settle_q <= '0;
                        state_q  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        if (num_q == '0) begin
                            pass_q  <= ~timeout_q;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            addr_q  <= base_q;
                            idx_q   <= '0;
                            state_q <= S_READ;
                        end
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                S_READ: begin
                    correct_q <= correct_d;
                    // idx == N is the trailing cycle that compares the last word.
                    if (idx_q == num_q) begin
                        pass_q  <= (correct_d == num_q) && !timeout_q;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q + 1'b1 != num_q) begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign seq_busy                   = busy_q;
    assign done                       = done_q;
    assign pass                       = pass_q;
    assign timeout                    = timeout_q;
    assign correct_count              = correct_q;
    assign cycle_count                = cyc_q;
    assign bus.dut_run                = run_q;
    assign bus.res_sram_read_address  = addr_q;
    assign bus.gold_sram_read_address = addr_q;
endmodule

// File: tb/tb_cnn_run_checker.sv
// Scoreboard bench for cnn_run_checker with a behavioural accelerator
// (busy delay/hold) and two 1-cycle-latency SRAM models.
module tb_cnn_run_checker;
    typedef struct {
        logic [12:0] cc;
        logic        ps;
        logic        to;
        logic [31:0] cyc;
    } exp_t;

    typedef struct {
        int          t;
        logic [11:0] a;
    } alog_t;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        start;
    logic [11:0] result_base;
    logic [12:0] num_results;
    logic        seq_busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [12:0] correct_count;
    logic [31:0] cycle_count;

    cnn_run_checker_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus();

    cnn_run_checker dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .start         (start),
        .result_base   (result_base),
        .num_results   (num_results),
        .seq_busy      (seq_busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .correct_count (correct_count),
        .cycle_count   (cycle_count),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int run_hi   = 0;
    int cyc_n    = 0;

    exp_t  exp_q[$];
    alog_t addr_log[$];

    logic [15:0] res_mem  [4096];
    logic [15:0] gold_mem [4096];

    // accelerator model
    int   busy_delay = 2;
    int   busy_hold  = 50;
    logic never_busy = 1'b0;
    logic m_busy;
    logic run_prev;
    logic arm;
    int   dly;
    int   hold;

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m_busy   <= 1'b0;
            run_prev <= 1'b0;
            arm      <= 1'b0;
            dly      <= 0;
            hold     <= 0;
        end else begin
            run_prev <= bus.dut_run;
            if (bus.dut_run && !run_prev && !never_busy) begin
                arm <= 1'b1;
                dly <= busy_delay - 1;
            end else if (arm) begin
                if (dly == 1) begin
                    arm    <= 1'b0;
                    m_busy <= 1'b1;
                    hold   <= busy_hold;
                end else begin
                    dly <= dly - 1;
                end
            end
            if (m_busy) begin
                if (hold == 1) m_busy <= 1'b0;
                else hold <= hold - 1;
            end
        end
    end

    assign bus.dut_busy = m_busy;

    always @(posedge clk) begin
        bus.res_sram_read_data  <= res_mem[bus.res_sram_read_address];
        bus.gold_sram_read_data <= gold_mem[bus.gold_sram_read_address];
        cyc_n <= cyc_n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // monitor: address log, dut_run width, done scoreboard
    logic        done_prev = 1'b0;
    logic [11:0] last_addr = '0;

    always @(negedge clk) begin
        if (bus.dut_run) run_hi++;
        if (bus.res_sram_read_address != last_addr) begin
            addr_log.push_back('{t: cyc_n, a: bus.res_sram_read_address});
            last_addr = bus.res_sram_read_address;
        end
        if (reset_b && done) begin
            chk("done_width", {31'd0, done_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("correct_count", {19'd0, correct_count}, {19'd0, e.cc});
                chk("pass", {31'd0, pass}, {31'd0, e.ps});
                chk("timeout", {31'd0, timeout}, {31'd0, e.to});
                chk("cycle_count", cycle_count, e.cyc);
                chk("gold_addr_eq", {20'd0, bus.gold_sram_read_address},
                    {20'd0, bus.res_sram_read_address});
            end
            done_cnt++;
        end
        done_prev = done;
    end

    task automatic start_seq(input logic [11:0] base, input logic [12:0] n,
                             input exp_t e);
        exp_q.push_back(e);
        @(negedge clk);
        addr_log.delete();
        run_hi      = 0;
        result_base = base;
        num_results = n;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("seq_busy_rise", {31'd0, seq_busy}, 32'd1);
    endtask

    task automatic wait_done();
        int c0;
        c0 = done_cnt;
        for (int k = 0; k < 3000 && done_cnt == c0; k++) @(negedge clk);
        if (done_cnt == c0) chk("done_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {27'd0, seq_busy, done, pass, timeout,
            bus.dut_run}, 32'd0);
        chk({tag, "_correct"}, {19'd0, correct_count}, 32'd0);
        chk({tag, "_cycles"}, cycle_count, 32'd0);
        chk({tag, "_addr"}, {8'd0, bus.res_sram_read_address,
            bus.gold_sram_read_address}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            res_mem[i]  = 16'(i * 3) ^ 16'h5a5a;
            gold_mem[i] = 16'(i * 3) ^ 16'h5a5a;
        end
        reset_b     = 1'b0;
        start       = 1'b0;
        result_base = '0;
        num_results = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        // nominal
        start_seq(12'h000, 13'd4, '{cc: 13'd4, ps: 1'b1, to: 1'b0, cyc: 32'd52});
        wait_done();
        chk("dut_run_high_cycles", run_hi, 32'd3);

        // mismatch on word 2
        gold_mem[2] = gold_mem[2] ^ 16'h0100;
        start_seq(12'h000, 13'd4, '{cc: 13'd3, ps: 1'b0, to: 1'b0, cyc: 32'd52});
        wait_done();
        gold_mem[2] = gold_mem[2] ^ 16'h0100;

        // wrap around the top of the address space
        start_seq(12'hFFE, 13'd3, '{cc: 13'd3, ps: 1'b1, to: 1'b0, cyc: 32'd52});
        wait_done();
        chk("wrap_log_len", addr_log.size(), 32'd3);
        if (addr_log.size() == 3) begin
            chk("wrap_a0", {20'd0, addr_log[0].a}, 32'hFFE);
            chk("wrap_a1", {20'd0, addr_log[1].a}, 32'hFFF);
            chk("wrap_a2", {20'd0, addr_log[2].a}, 32'h000);
            chk("wrap_t1", addr_log[1].t, addr_log[0].t + 1);
            chk("wrap_t2", addr_log[2].t, addr_log[1].t + 1);
        end

        // single word
        start_seq(12'h000, 13'd1, '{cc: 13'd1, ps: 1'b1, to: 1'b0, cyc: 32'd52});
        wait_done();

        // timeout: busy never rises
        never_busy = 1'b1;
        start_seq(12'h123, 13'd4, '{cc: 13'd0, ps: 1'b0, to: 1'b1, cyc: 32'd1024});
        wait_done();
        chk("timeout_dut_run", {31'd0, bus.dut_run}, 32'd0);
        chk("timeout_no_reads", addr_log.size(), 32'd0);
        chk("timeout_run_cycles", run_hi, 32'd1024);
        @(negedge clk);
        chk("timeout_sticky", {31'd0, timeout}, 32'd1);
        never_busy = 1'b0;

        // N=0 with an ignored start while busy
        start_seq(12'h000, 13'd0, '{cc: 13'd0, ps: 1'b1, to: 1'b0, cyc: 32'd52});
        repeat (20) @(negedge clk);
        result_base = 12'h100;
        num_results = 13'd5;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("n0_no_reads", addr_log.size(), 32'd0);
        chk("n0_idle", {31'd0, seq_busy}, 32'd0);

        // reset while waiting for busy to fall
        start_seq(12'h000, 13'd4, '{cc: 13'd4, ps: 1'b1, to: 1'b0, cyc: 32'd52});
        repeat (20) @(negedge clk);
        chk("midrun_in_wait_done", {30'd0, m_busy, bus.dut_run}, 32'd2);
        #2;
        reset_b = 1'b0;
        #1;
        chk_zero("midrun_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        start_seq(12'h000, 13'd4, '{cc: 13'd4, ps: 1'b1, to: 1'b0, cyc: 32'd52});
        wait_done();
        chk("post_reset_dut_run", run_hi, 32'd3);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
